lutram_fifo_ctrl: RTL and testbench
===================================

# lutram_fifo_ctrl

Synchronous 32-entry FIFO controller built around 32x1 dual-port distributed RAM. WIDTH bit-slices share one write/read address pair. The block owns the write and read pointers, full/empty/level tracking and valid/ready handshakes on both sides. It sequences the RAM write port (A, WE) and the async read port (DPRA). It is the standard small elastic buffer between streaming stages in the design.

## Interface
- WIDTH, 8: data width; one 32x1 RAM slice per bit.
- AFULL_LVL, 28: AFULL asserts when LEVEL >= AFULL_LVL (legal 1..32).
- AEMPTY_LVL, 4: AEMPTY asserts when LEVEL <= AEMPTY_LVL (legal 0..31).

- CLK  in  1  single clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset; deassertion is synchronous to CLK upstream.
- CLR  in  1  synchronous flush: empties the FIFO and has priority over writes and reads.
- WR_VALID  in  1  write request.
- WR_READY  out  1  FIFO can accept a word (not full).
- WR_DATA  in  WIDTH  write data.
- RD_VALID  out  1  head word present on RD_DATA.
- RD_READY  in  1  consumer takes the head word.
- RD_DATA  out  WIDTH  head word; don't-care while RD_VALID=0.
- LEVEL  out  6  words held, 0..32 (0..33 with the output register).
- AFULL  out  1  almost-full flag.
- AEMPTY  out  1  almost-empty flag.

## Operation
- Pointers: wr_ptr and rd_ptr are 6 bits each, 5-bit address plus a wrap bit. Empty when the pointers are equal. Full when the addresses are equal and the wrap bits differ.
- Write fires on WR_VALID & WR_READY: WE=1 with A=wr_ptr[4:0], then wr_ptr+1.
- Read fires on RD_VALID & RD_READY: rd_ptr+1.
- Both increments wrap modulo 64, so address 31 wraps to 0.
- WR_READY = !full and RD_VALID = !empty. Both are decoded from registered state only, with no combinational path from WR_VALID or RD_READY.
- Simultaneous write and read:
  - When neither full nor empty: both fire and LEVEL is unchanged.
  - When full: only the read fires, since WR_READY=0.
  - When empty: only the write fires, since RD_VALID=0.
- LEVEL, AFULL and AEMPTY are registered. They are updated in the same edge as the pointers.
- CLR: both pointers go to 0, LEVEL=0, and any concurrent write or read is ignored. RAM contents are not cleared.
- Reset values: WR_READY=1, RD_VALID=0, LEVEL=0, AFULL=0, AEMPTY=1. RD_DATA is undefined.
- Reset mid-operation (RST_N low at any time) returns immediately to the reset values. RAM contents are not reset.
- Writing while WR_READY=0 is dropped silently, with no state change. Reading while RD_VALID=0 is ignored.

## Timing
- Write-to-read latency: a word accepted at edge N gives RD_VALID=1 and valid RD_DATA after edge N. RD_DATA comes combinationally from the RAM read port.
- Back-to-back: one write and one read per cycle sustained. Throughput is 1 word/clock on each side.
- Flags lag the accepting edge by zero cycles; they reflect the post-edge state.
- Full recovery: after a read at edge N on a full FIFO, WR_READY=1 after edge N.

## Configuration
- LUTRAM_FIFO_OREG_EN defined:
  - RD_DATA comes from a WIDTH-bit output register loaded from the RAM whenever the register is empty or being consumed.
  - Write-to-RD_VALID latency becomes 2 edges.
  - Capacity becomes 33 and LEVEL counts the register.
  - WR_READY depends only on the RAM full condition.
- Undefined:
  - RD_DATA is the asynchronous RAM read.
  - Capacity is 32 and latency is 1 edge.

## Structure
- Shared package lutram_fifo_pkg holds:
  - localparams: DEPTH=32, AW=5, PW=6, LW=6
  - a ptr_t typedef for 6-bit pointers
  - a level_t typedef for 6-bit levels
- Sub-module lutram_fifo_mem instantiates WIDTH RAM32X1D slices via generate:
  - A driven by wr_ptr[4:0]
  - DPRA driven by rd_ptr[4:0]
  - shared WCLK=CLK and WE
  - DPO bus out

## Test plan
- Reset then idle -> WR_READY=1, RD_VALID=0, LEVEL=0, AEMPTY=1, AFULL=0.
- Write 32 words 0x00..0x1F back-to-back with RD_READY=0 -> WR_READY=0 after the 32nd edge, LEVEL=32, AFULL=1 from LEVEL 28. A 33rd write is dropped.
- Drain 32 words -> RD_DATA sequence 0x00..0x1F, RD_VALID=0 after the last read, AEMPTY=1 from LEVEL 4.
- Continuous write+read for 100 cycles with an incrementing pattern:
  - LEVEL is constant and data is in order.
  - Pointers wrap past 31 with no loss.
- Full FIFO, WR_VALID=1 and RD_READY=1 in the same cycle -> read fires, write stalls, LEVEL=31. The next cycle the write is accepted.
- 10 words loaded, then CLR=1 with WR_VALID=1 -> LEVEL=0, RD_VALID=0, write ignored. With LUTRAM_FIFO_OREG_EN, also check the 2-edge latency and that LEVEL reaches 33.

Source files
------------

// File: rtl/lutram_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lutram_fifo_pkg
//  Purpose  : Shared sizes, pointer/level types and helpers for the
//             32-entry distributed-RAM FIFO controller.
//  Revision : 1.0  initial release
// ============================================================================
package lutram_fifo_pkg;

    localparam int DEPTH = 32;  // RAM words per bit-slice
    localparam int AW    = 5;   // RAM address width
    localparam int PW    = 6;   // pointer width: address plus wrap bit
    localparam int LW    = 6;   // level width: 0..33

    typedef logic [PW-1:0] ptr_t;
    typedef logic [LW-1:0] level_t;

    // Same RAM address on opposite laps means every slot is occupied.
    function automatic logic ptrs_full(input ptr_t wr, input ptr_t rd);
        return (wr[AW-1:0] == rd[AW-1:0]) && (wr[AW] != rd[AW]);
    endfunction

endpackage : lutram_fifo_pkg
`default_nettype wire

// File: rtl/lutram_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : lutram_fifo_ctrl_if
//  Purpose  : Write/read handshake and status bundle of the FIFO.
//             master = producer/consumer side, slave = the FIFO itself.
//  Revision : 1.0  initial release
// ============================================================================
interface lutram_fifo_ctrl_if #(
    parameter int WIDTH = 8
) ();
    import lutram_fifo_pkg::*;

    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;
    level_t           level;
    logic             afull;
    logic             aempty;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, level, afull, aempty
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, level, afull, aempty
    );

endinterface : lutram_fifo_ctrl_if
`default_nettype wire

// File: rtl/lutram_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : lutram_fifo_mem
//  Purpose  : WIDTH slices of 32x1 dual-port distributed RAM (RAM32X1D
//             behaviour): synchronous write on port A, asynchronous read
//             on DPRA. Contents are never reset.
//  Revision : 1.0  initial release
// ============================================================================
module lutram_fifo_mem
    import lutram_fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             we,
    input  wire logic [AW-1:0]    a,
    input  wire logic [AW-1:0]    dpra,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] dpo
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        logic [DEPTH-1:0] ram_q;
        logic [DEPTH-1:0] ram_d;

        // Next RAM image: only the addressed cell changes on a write.
        always_comb begin
            ram_d = ram_q;
            if (we) begin
                ram_d[a] = d[i];
            end
        end

        // RAM cells have no reset, matching the LUT primitive.
        always_ff @(posedge clk) begin
            ram_q <= ram_d;
        end

        assign dpo[i] = ram_q[dpra];
    end : g_slice

endmodule : lutram_fifo_mem
`default_nettype wire

// File: rtl/lutram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lutram_fifo_ctrl
//  Purpose  : 32-entry elastic buffer controller over distributed RAM:
//             pointers, level, almost-full/empty flags and handshakes.
//             Build option LUTRAM_FIFO_OREG_EN adds a registered output
//             stage (capacity 33, write-to-valid latency 2 edges).
//  Revision : 1.0  initial release
// ============================================================================
module lutram_fifo_ctrl
    import lutram_fifo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int AFULL_LVL  = 28,
    parameter int AEMPTY_LVL = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       clr,
    lutram_fifo_ctrl_if.slave bus
);

    localparam level_t c_afull_lvl  = level_t'(AFULL_LVL);
    localparam level_t c_aempty_lvl = level_t'(AEMPTY_LVL);

    ptr_t       wr_ptr_q, wr_ptr_d;
    ptr_t       rd_ptr_q, rd_ptr_d;
    level_t     level_q,  level_d;
    logic       afull_q,  afull_d;
    logic       aempty_q, aempty_d;

    logic       ram_full;
    logic       ram_empty;
    logic       wr_fire;      // word accepted into RAM
    logic       ram_rd_fire;  // RAM head leaves (to consumer or output reg)
    logic       out_fire;     // consumer takes a word
    logic [WIDTH-1:0] ram_dpo;

    // Status decoded from registered pointers only: no path from valid/ready.
    assign ram_empty = (wr_ptr_q == rd_ptr_q);
    assign ram_full  = ptrs_full(wr_ptr_q, rd_ptr_q);
    assign wr_fire   = bus.wr_valid & ~ram_full;

`ifdef LUTRAM_FIFO_OREG_EN
    logic             oreg_valid_q, oreg_valid_d;
    logic [WIDTH-1:0] oreg_data_q,  oreg_data_d;

    // Refill the output register whenever it is empty or being drained.
    assign out_fire    = oreg_valid_q & bus.rd_ready;
    assign ram_rd_fire = ~ram_empty & (~oreg_valid_q | bus.rd_ready);

    // Output register next state; flush drops the held word.
    always_comb begin
        oreg_valid_d = oreg_valid_q;
        oreg_data_d  = oreg_data_q;
        if (ram_rd_fire) begin
            oreg_data_d = ram_dpo;
        end
        if (clr) begin
            oreg_valid_d = 1'b0;
        end else if (ram_rd_fire) begin
            oreg_valid_d = 1'b1;
        end else if (out_fire) begin
            oreg_valid_d = 1'b0;
        end
    end

    // Output register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oreg_valid_q <= 1'b0;
            oreg_data_q  <= '0;
        end else begin
            oreg_valid_q <= oreg_valid_d;
            oreg_data_q  <= oreg_data_d;
        end
    end

    assign bus.rd_valid = oreg_valid_q;
    assign bus.rd_data  = oreg_data_q;
`else
    assign out_fire     = ~ram_empty & bus.rd_ready;
    assign ram_rd_fire  = out_fire;
    assign bus.rd_valid = ~ram_empty;
    assign bus.rd_data  = ram_dpo;
`endif

    // Pointer, level and flag next state; flush wins over any transfer.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            if (ram_rd_fire) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
            level_d = level_q + {{(LW-1){1'b0}}, wr_fire}
                              - {{(LW-1){1'b0}}, out_fire};
        end
        afull_d  = (level_d >= c_afull_lvl);
        aempty_d = (level_d <= c_aempty_lvl);
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

    assign bus.wr_ready = ~ram_full;
    assign bus.level    = level_q;
    assign bus.afull    = afull_q;
    assign bus.aempty   = aempty_q;

    lutram_fifo_mem #(
        .WIDTH (WIDTH)
    ) u_mem (
        .clk  (clk),
        .we   (wr_fire & ~clr),
        .a    (wr_ptr_q[AW-1:0]),
        .dpra (rd_ptr_q[AW-1:0]),
        .d    (bus.wr_data),
        .dpo  (ram_dpo)
    );

endmodule : lutram_fifo_ctrl
`default_nettype wire

// File: tb/tb_lutram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lutram_fifo_ctrl
//  Purpose  : Directed self-checking bench for lutram_fifo_ctrl: reset,
//             fill/overflow, full simultaneous access, drain, streaming
//             with pointer wrap, flush and asynchronous reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lutram_fifo_ctrl;

`ifdef LUTRAM_FIFO_OREG_EN
    localparam int CAP = 33;
    localparam int LAT = 2;
`else
    localparam int CAP = 32;
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst_n;
    logic clr;

    int n_checks;
    int n_errors;

    lutram_fifo_ctrl_if #(.WIDTH(8)) bus ();

    lutram_fifo_ctrl #(
        .WIDTH      (8),
        .AFULL_LVL  (28),
        .AEMPTY_LVL (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input int lvl,
                                input logic wr_rdy, input logic rd_vld);
        check_eq({tag, ".level"},  32'(bus.level),    32'(lvl));
        check_eq({tag, ".afull"},  32'(bus.afull),    32'(lvl >= 28));
        check_eq({tag, ".aempty"}, 32'(bus.aempty),   32'(lvl <= 4));
        check_eq({tag, ".wr_rdy"}, 32'(bus.wr_ready), 32'(wr_rdy));
        check_eq({tag, ".rd_vld"}, 32'(bus.rd_valid), 32'(rd_vld));
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        clr          = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;

        // ---------------- reset then idle ----------------
        repeat (2) @(posedge clk);
        #1;
        check_status("in_rst", 0, 1'b1, 1'b0);
        rst_n = 1'b1;
        tick();
        tick();
        check_status("idle", 0, 1'b1, 1'b0);

        // ---------------- fill to capacity ----------------
        for (int i = 0; i < CAP; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'(i);
            tick();
            check_status($sformatf("fill%0d", i), i + 1, (i + 1) < CAP,
                         (i + 1) >= LAT);
        end
        // Overflow attempt is dropped.
        bus.wr_data = 8'hAA;
        tick();
        check_status("ovf", CAP, 1'b0, 1'b1);

        // ---------------- full with write+read together ----------------
        bus.wr_data  = 8'(CAP);
        bus.rd_ready = 1'b1;
        check_eq("full_head", 32'(bus.rd_data), 32'h00);
        tick();
        check_status("full_wr_rd", CAP - 1, 1'b1, 1'b1);
        bus.rd_ready = 1'b0;
        tick();
        check_status("full_retry", CAP, 1'b0, 1'b1);
        bus.wr_valid = 1'b0;

        // ---------------- drain ----------------
        bus.rd_ready = 1'b1;
        for (int k = 0; k < CAP; k++) begin
            check_eq($sformatf("drain%0d.data", k), 32'(bus.rd_data), 32'(k + 1));
            check_eq($sformatf("drain%0d.vld", k), 32'(bus.rd_valid), 32'd1);
            tick();
            check_status($sformatf("drain%0d", k), CAP - 1 - k, 1'b1,
                         (CAP - 1 - k) > 0);
        end
        bus.rd_ready = 1'b0;
        tick();
        check_status("drained", 0, 1'b1, 1'b0);

        // ---------------- streaming with pointer wrap ----------------
        bus.wr_valid = 1'b1;
        bus.rd_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            bus.wr_data = 8'(8'h40 + c);
            if (c >= LAT) begin
                check_eq($sformatf("strm%0d.data", c), 32'(bus.rd_data),
                         32'(8'h40 + c - LAT));
                check_eq($sformatf("strm%0d.vld", c), 32'(bus.rd_valid), 32'd1);
            end
            tick();
            check_eq($sformatf("strm%0d.level", c), 32'(bus.level),
                     32'((c + 1) < LAT ? c + 1 : LAT));
        end
        bus.wr_valid = 1'b0;
        for (int j = 0; j < LAT; j++) begin
            check_eq($sformatf("strm_tail%0d", j), 32'(bus.rd_data),
                     32'(8'h40 + 100 - LAT + j));
            tick();
        end
        bus.rd_ready = 1'b0;
        check_status("strm_end", 0, 1'b1, 1'b0);

        // ---------------- flush ----------------
        for (int i = 0; i < 10; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'(8'h80 + i);
            tick();
        end
        check_status("preclr", 10, 1'b1, 1'b1);
        clr         = 1'b1;
        bus.wr_data = 8'hEE;
        tick();
        check_status("clr", 0, 1'b1, 1'b0);
        clr          = 1'b0;
        bus.wr_valid = 1'b0;
        tick();
        check_status("postclr", 0, 1'b1, 1'b0);

        // Write-to-valid latency after flush.
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h5A;
        tick();
        bus.wr_valid = 1'b0;
        check_eq("lat_edge1", 32'(bus.rd_valid), 32'(LAT == 1));
        tick();
        check_eq("lat_edge2", 32'(bus.rd_valid), 32'd1);
        check_eq("lat_data", 32'(bus.rd_data), 32'h5A);
        check_eq("lat_level", 32'(bus.level), 32'd1);

        // ---------------- asynchronous reset mid-operation ----------------
        #2;
        rst_n = 1'b0;
        #1;
        check_status("async_rst", 0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check_status("after_rst", 0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_lutram_fifo_ctrl
`default_nettype wire
